clk_div_multi: RTL and testbench

//  - NUM_CH independent clock dividers run from the single system clock `clk`.
//  - Each channel has a runtime-programmable divide count and a mode:

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_multi_if.sv | 33 +++
 rtl/clk_div_ch.sv | 91 +++++++++
 rtl/clk_div_multi.sv | 41 ++++
 tb/tb_clk_div_multi.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Mode encodings, reset divide count and config-index width helper.
package clk_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int DEFAULT_DIV = 2200;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration bus for clk_div_multi.
// The master writes divide/mode; the slave reports pending shadows.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  import clk_div_pkg::*;

  localparam int CH_W = ch_w(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic [NUM_CH-1:0] cfg_pending;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    output cfg_mode,
    input  cfg_pending
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_mode,
    output cfg_pending
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: up-counter, shadow/active config,
// TOGGLE or PULSE output with registered tick.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int DIV_RST = 2200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [CNT_W-1:0] div,
  input  logic             mode,
  output logic             sclk,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_div;
  logic [CNT_W-1:0] sh_div;
  logic             act_mode;
  logic             sh_mode;

  logic             wrap;
  logic [CNT_W-1:0] nxt_div;
  logic             nxt_mode;

  // A write in the same cycle beats the stored shadow.
  always_comb begin
    wrap     = (cnt == act_div);
    nxt_div  = act_div;
    nxt_mode = act_mode;
    if (we) begin
      nxt_div  = div;
      nxt_mode = mode;
    end else if (pending) begin
      nxt_div  = sh_div;
      nxt_mode = sh_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      act_div  <= DIV_INIT;
      sh_div   <= DIV_INIT;
      act_mode <= MODE_TOGGLE;
      sh_mode  <= MODE_TOGGLE;
      pending  <= 1'b0;
      sclk     <= 1'b0;
      tick     <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      sclk     <= 1'b0;
      tick     <= 1'b0;
      act_div  <= nxt_div;
      act_mode <= nxt_mode;
      pending  <= 1'b0;
      if (we) begin
        sh_div  <= div;
        sh_mode <= mode;
      end
    end else begin
      tick <= wrap;
      if (we) begin
        sh_div  <= div;
        sh_mode <= mode;
      end
      if (wrap) begin
        cnt      <= '0;
        act_div  <= nxt_div;
        act_mode <= nxt_mode;
        pending  <= 1'b0;
        // Restart low on a mode change so no runt pulse escapes.
        if (nxt_mode == MODE_PULSE || nxt_mode != act_mode)
          sclk <= 1'b0;
        else
          sclk <= ~sclk;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (we)
          pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers.
// Stateless wrapper: decodes the config channel and fans out.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] sclk,
  output logic [NUM_CH-1:0] tick,
  clk_div_multi_if.slave    cfg
);

  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] pend;

  assign cfg.cfg_pending = pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers match no channel.
    assign we[i] = cfg.cfg_we && (int'(cfg.cfg_ch) == i);

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .we      (we[i]),
      .div     (cfg.cfg_div),
      .mode    (cfg.cfg_mode),
      .sclk    (sclk[i]),
      .tick    (tick[i]),
      .pending (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: vector table, corner sequences,
// and random traffic against a countdown reference model.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int NCH = 5;
  localparam int CW  = 16;
  localparam int DEF = 2200;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic [NCH-1:0] sclk;
  logic [NCH-1:0] tick;

  logic [0:0] b_en;
  logic [0:0] b_sclk;
  logic [0:0] b_tick;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(CW)) cif ();
  clk_div_multi_if #(.NUM_CH(1), .CNT_W(4)) bif ();

  clk_div_multi #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .sclk(sclk), .tick(tick), .cfg(cif.slave)
  );

  clk_div_multi #(
    .NUM_CH(1), .CNT_W(4), .DEFAULT_DIV(15)
  ) dut_b (
    .clk(clk), .rst(rst), .en(b_en),
    .sclk(b_sclk), .tick(b_tick), .cfg(bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d, input logic m);
    cif.cfg_we   = 1'b1;
    cif.cfg_ch   = 3'(ch);
    cif.cfg_div  = 16'(d);
    cif.cfg_mode = m;
    step();
    cif.cfg_we = 1'b0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    en  = '0;
    cif.cfg_we = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Reference model: cycles remaining until the next wrap.
  int   m_rem [NCH];
  int   m_act [NCH];
  int   m_sh  [NCH];
  logic m_md  [NCH];
  logic m_shm [NCH];
  logic m_pnd [NCH];
  logic m_sck [NCH];
  logic m_tck [NCH];

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      logic w;
      logic old;
      w = cif.cfg_we && (int'(cif.cfg_ch) == c);
      if (rst) begin
        m_act[c] = DEF; m_sh[c] = DEF;
        m_md[c] = MODE_TOGGLE; m_shm[c] = MODE_TOGGLE;
        m_pnd[c] = 0; m_sck[c] = 0; m_tck[c] = 0;
        m_rem[c] = DEF + 1;
      end else if (!en[c]) begin
        if (w) begin
          m_sh[c] = int'(cif.cfg_div); m_shm[c] = cif.cfg_mode;
          m_act[c] = m_sh[c]; m_md[c] = m_shm[c];
        end else if (m_pnd[c]) begin
          m_act[c] = m_sh[c]; m_md[c] = m_shm[c];
        end
        m_pnd[c] = 0; m_sck[c] = 0; m_tck[c] = 0;
        m_rem[c] = m_act[c] + 1;
      end else begin
        m_rem[c]--;
        if (w) begin
          m_sh[c] = int'(cif.cfg_div); m_shm[c] = cif.cfg_mode;
        end
        if (m_rem[c] == 0) begin
          old = m_md[c];
          if (w || m_pnd[c]) begin
            m_act[c] = m_sh[c]; m_md[c] = m_shm[c];
          end
          m_pnd[c] = 0;
          m_tck[c] = 1;
          m_rem[c] = m_act[c] + 1;
          if (m_md[c] == MODE_PULSE || m_md[c] != old) m_sck[c] = 0;
          else m_sck[c] = ~m_sck[c];
        end else begin
          m_tck[c] = 0;
          if (w) m_pnd[c] = 1;
        end
      end
    end
  endtask

  typedef struct {
    int   ch;
    int   div;
    logic mode;
    int   ticks;
    int   first;
    int   highs;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic s [41];
    logic t [41];
    logic p [41];
    int cnt_a, cnt_b, cnt_c, cnt_d;
    int since, idx;
    logic [NCH-1:0] es, et, ep;

    vt[0] = '{1, 0, MODE_TOGGLE, 24, 1, 12};
    vt[1] = '{3, 4, MODE_PULSE,   4, 5,  0};
    vt[2] = '{0, 1, MODE_TOGGLE, 12, 2, 12};
    vt[3] = '{2, 2, MODE_TOGGLE,  8, 3, 12};
    vt[4] = '{4, 6, MODE_TOGGLE,  3, 7, 11};
    vt[5] = '{1, 5, MODE_PULSE,   4, 6,  0};

    bif.cfg_we = 1'b0; bif.cfg_ch = 1'b0;
    bif.cfg_div = 4'd0; bif.cfg_mode = 1'b0;
    b_en = 1'b0;
    cif.cfg_ch = '0; cif.cfg_div = '0; cif.cfg_mode = 1'b0;

    // Reset defaults and first wrap at DEFAULT_DIV+1.
    reset_all();
    chk("rst_sclk", 64'(sclk), 0);
    chk("rst_tick", 64'(tick), 0);
    chk("rst_pend", 64'(cif.cfg_pending), 0);
    en = 5'b00001;
    n = 5000;
    for (int k = 1; k <= 5000; k++) begin
      step();
      if (sclk[0]) begin n = k; break; end
    end
    chk("rst_first_rise", n, DEF + 1);
    chk("rst_first_tick", 64'(tick[0]), 1);
    n = 5000;
    for (int k = 1; k <= 5000; k++) begin
      step();
      if (!sclk[0]) begin n = k; break; end
    end
    chk("rst_half_period", n, DEF + 1);
    chk("rst_second_tick", 64'(tick[0]), 1);

    // Table-driven single-channel runs.
    for (int v = 0; v < 6; v++) begin
      en = '0;
      wr(vt[v].ch, vt[v].div, vt[v].mode);
      chk("vec_pend", 64'(cif.cfg_pending), 0);
      en = NCH'(1) << vt[v].ch;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int k = 1; k <= 24; k++) begin
        step();
        if (tick[vt[v].ch]) begin
          cnt_a++;
          if (cnt_b == 0) cnt_b = k;
        end
        if (sclk[vt[v].ch]) cnt_c++;
      end
      chk($sformatf("vec%0d_ticks", v), cnt_a, vt[v].ticks);
      chk($sformatf("vec%0d_first", v), cnt_b, vt[v].first);
      chk($sformatf("vec%0d_highs", v), cnt_c, vt[v].highs);
    end

    // Glitch-free reconfig: D=9 -> D=3 written at cnt=4.
    reset_all();
    wr(0, 9, MODE_TOGGLE);
    en = 5'b00001;
    cnt_a = 0;
    for (int k = 1; k <= 30; k++) begin
      cif.cfg_we = (k == 5);
      cif.cfg_ch = 3'd0; cif.cfg_div = 16'd3;
      cif.cfg_mode = MODE_TOGGLE;
      step();
      s[k] = sclk[0]; p[k] = cif.cfg_pending[0];
      cnt_a += int'(p[k]);
    end
    cif.cfg_we = 1'b0;
    chk("rcfg_pend_len", cnt_a, 5);
    chk("rcfg_pend_on", 64'(p[5]), 1);
    chk("rcfg_pend_off", 64'(p[10]), 0);
    chk("rcfg_pre_wrap", 64'(s[9]), 0);
    chk("rcfg_rise", 64'(s[10]), 1);
    chk("rcfg_hold", 64'(s[13]), 1);
    chk("rcfg_fall", 64'(s[14]), 0);
    chk("rcfg_rise2", 64'(s[18]), 1);

    // Write coincident with wrap: D=5 -> D=2 on the wrap edge.
    reset_all();
    wr(2, 5, MODE_TOGGLE);
    en = 5'b00100;
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 14; k++) begin
      cif.cfg_we = (k == 6);
      cif.cfg_ch = 3'd2; cif.cfg_div = 16'd2;
      cif.cfg_mode = MODE_TOGGLE;
      step();
      t[k] = tick[2];
      cnt_a += int'(tick[2]);
      cnt_b += int'(cif.cfg_pending[2]);
    end
    cif.cfg_we = 1'b0;
    chk("coin_tick6", 64'(t[6]), 1);
    chk("coin_tick9", 64'(t[9]), 1);
    chk("coin_tick12", 64'(t[12]), 1);
    chk("coin_ticks", cnt_a, 3);
    chk("coin_pend", cnt_b, 0);

    // PULSE ch3 alongside TOGGLE ch0 with traffic to ch1.
    reset_all();
    wr(3, 4, MODE_PULSE);
    wr(0, 1, MODE_TOGGLE);
    en = 5'b01001;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int k = 1; k <= 20; k++) begin
      cif.cfg_we = (k % 4 == 2);
      cif.cfg_ch = 3'd1;
      cif.cfg_div = 16'($urandom_range(0, 7));
      cif.cfg_mode = 1'($urandom_range(0, 1));
      step();
      cnt_a += int'(tick[3]); cnt_b += int'(sclk[3]);
      cnt_c += int'(tick[0]); cnt_d += int'(sclk[0]);
    end
    cif.cfg_we = 1'b0;
    chk("pulse_ticks3", cnt_a, 4);
    chk("pulse_sclk3", cnt_b, 0);
    chk("indep_ticks0", cnt_c, 10);
    chk("indep_highs0", cnt_d, 10);

    // Disable mid-count, re-enable, then reset mid-count.
    reset_all();
    wr(0, 9, MODE_TOGGLE);
    wr(1, 0, MODE_TOGGLE);
    for (int k = 1; k <= 30; k++) begin
      en = (k == 18) ? 5'b00010 : 5'b00011;
      step();
      s[k] = sclk[0]; t[k] = tick[0];
    end
    chk("dis_before", 64'(s[17]), 1);
    chk("dis_sclk", 64'(s[18]), 0);
    chk("dis_tick", 64'(t[18]), 0);
    chk("reen_pre", 64'(s[27]), 0);
    chk("reen_notick", 64'(t[27]), 0);
    chk("reen_tick", 64'(t[28]), 1);
    chk("reen_rise", 64'(s[28]), 1);
    rst = 1'b1;
    cif.cfg_we = 1'b1; cif.cfg_ch = 3'd3; cif.cfg_div = 16'd1;
    step();
    cif.cfg_we = 1'b0;
    chk("midrst_sclk", 64'(sclk), 0);
    chk("midrst_tick", 64'(tick), 0);
    chk("midrst_pend", 64'(cif.cfg_pending), 0);
    rst = 1'b0;
    step(); step();
    chk("midrst_div", 64'(tick[1]), 0);
    chk("midrst_pend2", 64'(cif.cfg_pending), 0);

    // Out-of-range channel numbers are ignored.
    en = '1;
    for (int c = 5; c <= 7; c++) begin
      wr(c, 0, MODE_PULSE);
      chk($sformatf("oor_ch%0d", c), 64'(cif.cfg_pending), 0);
    end
    wr(4, 0, MODE_PULSE);
    chk("inrange_ch4", 64'(cif.cfg_pending), 64'h10);

    // Maximum divide 2^CNT_W-1 on a 4-bit instance.
    reset_all();
    b_en = 1'b1;
    cnt_a = 0;
    for (int k = 1; k <= 33; k++) begin
      step();
      t[k] = b_tick[0]; s[k] = b_sclk[0];
      cnt_a += int'(b_tick[0]);
    end
    chk("max_tick16", 64'(t[16]), 1);
    chk("max_tick32", 64'(t[32]), 1);
    chk("max_ticks", cnt_a, 2);
    chk("max_sclk", 64'(s[16]), 1);
    b_en = 1'b0;

    // Random traffic against the reference model.
    since = 0;
    en = '0;
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 999) == 0);
      cif.cfg_we = 1'b0;
      if (rst) begin
        since = 0;
      end else if (since < NCH) begin
        en = '0;
        cif.cfg_we = 1'b1;
        cif.cfg_ch = 3'(since);
        cif.cfg_div = 16'($urandom_range(0, 9));
        cif.cfg_mode = 1'($urandom_range(0, 1));
        since++;
      end else begin
        if (since == NCH) en = '1;
        since++;
        if ($urandom_range(0, 15) == 0) begin
          idx = $urandom_range(0, NCH - 1);
          en[idx] = ~en[idx];
        end
        if ($urandom_range(0, 4) == 0) begin
          cif.cfg_we = 1'b1;
          cif.cfg_ch = 3'($urandom_range(0, 7));
          cif.cfg_div = 16'($urandom_range(0, 9));
          cif.cfg_mode = 1'($urandom_range(0, 1));
        end
      end
      model_step();
      step();
      for (int c = 0; c < NCH; c++) begin
        es[c] = m_sck[c]; et[c] = m_tck[c]; ep[c] = m_pnd[c];
      end
      chk("rand_sclk", 64'(sclk), 64'(es));
      chk("rand_tick", 64'(tick), 64'(et));
      chk("rand_pend", 64'(cif.cfg_pending), 64'(ep));
    end
    cif.cfg_we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
